// File: rtl/dlock_pkg.sv
// Shared types and constants for the parametrised serial code lock.
package dlock_pkg;

    typedef enum logic {
        HUNT    = 1'b0,
        LOCKOUT = 1'b1
    } state_e;

    localparam logic [5:0] DEFAULT_CODE_6 = 6'b110100;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dlock_lockout_timer.sv
// Loadable down-counter that times the lockout window and pulses done on its last cycle.
module dlock_lockout_timer
    import dlock_pkg::*;
#(
    parameter int  LOCKOUT_CYCLES = 16,
    localparam int TMR_W = (LOCKOUT_CYCLES > 1) ? clog2(LOCKOUT_CYCLES) : 1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             busy,
    output logic             done
);

    logic [TMR_W-1:0] count_r;
    logic             busy_r;

    // Count down from the loaded value and go idle after reaching zero.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            count_r <= '0;
            busy_r  <= 1'b0;
        end else if (load) begin
            count_r <= load_val;
            busy_r  <= 1'b1;
        end else if (busy_r) begin
            if (count_r == '0) begin
                busy_r <= 1'b0;
            end else begin
                count_r <= count_r - TMR_W'(1);
            end
        end else begin
            count_r <= count_r;
            busy_r  <= busy_r;
        end
    end

    assign busy = busy_r;
    assign done = busy_r && (count_r == '0);

endmodule

// File: rtl/dlock_param.sv
// Serial code lock: sliding or framed comparison of a bit stream against a loadable code,
// with a timed lockout after repeated framed failures.
module dlock_param
    import dlock_pkg::*;
#(
    parameter int                  CODE_LEN       = 6,
    parameter logic [CODE_LEN-1:0] DEFAULT_CODE   = CODE_LEN'(DEFAULT_CODE_6),
    parameter bit                  OVERLAP        = 1'b1,
    parameter int                  MAX_FAIL       = 3,
    parameter int                  LOCKOUT_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             clear,
    input  logic                             d_in,
    input  logic                             d_valid,
    input  logic                             load_en,
    input  logic [CODE_LEN-1:0]              load_code,
    output logic                             unlock,
    output logic                             locked_out,
    output logic [clog2(MAX_FAIL+1)-1:0]     fail_cnt
);

    localparam int FAIL_W = clog2(MAX_FAIL + 1);
    localparam int CNT_W  = clog2(CODE_LEN);
    localparam int TMR_W  = (LOCKOUT_CYCLES > 1) ? clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CODE_LEN - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAIL);
    localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);

    state_e              state_r;
    logic [CODE_LEN-1:0] code_r;
    logic [CODE_LEN-2:0] hist_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [FAIL_W-1:0]   fail_r;
    logic                unlock_r;
    logic                locked_r;

    logic [CODE_LEN-1:0] cand_s;
    logic                hit_s;
    logic [FAIL_W-1:0]   fail_inc_s;
    logic                frame_end_s;
    logic                tmr_load_s;
    logic                tmr_busy_s;
    logic                tmr_done_s;

    // Candidate window, comparator and the lockout trigger for the current bit.
    always_comb begin
        cand_s      = {hist_r, d_in};
        hit_s       = (cand_s == code_r);
        fail_inc_s  = fail_r + FAIL_W'(1);
        frame_end_s = (state_r == HUNT) && !load_en && d_valid && !OVERLAP && (cnt_r == CNT_LAST);
        if (frame_end_s && !hit_s && (fail_inc_s == FAIL_MAX)) begin
            tmr_load_s = 1'b1;
        end else begin
            tmr_load_s = 1'b0;
        end
    end

    dlock_lockout_timer #(
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .clear    (clear),
        .load     (tmr_load_s),
        .load_val (TMR_LOAD),
        .busy     (tmr_busy_s),
        .done     (tmr_done_s)
    );

    // Lock FSM with history, bit counter, fail counter and registered outputs.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_r  <= HUNT;
            code_r   <= DEFAULT_CODE;
            hist_r   <= '0;
            cnt_r    <= '0;
            fail_r   <= '0;
            unlock_r <= 1'b0;
            locked_r <= 1'b0;
        end else begin
            unlock_r <= 1'b0;
            case (state_r)
                HUNT: begin
                    if (load_en) begin
                        code_r <= load_code;
                        hist_r <= '0;
                        cnt_r  <= '0;
                        fail_r <= '0;
                    end else if (d_valid) begin
                        if (OVERLAP) begin
                            hist_r   <= cand_s[CODE_LEN-2:0];
                            unlock_r <= hit_s && (cnt_r == CNT_LAST);
                            if (cnt_r != CNT_LAST) begin
                                cnt_r <= cnt_r + CNT_W'(1);
                            end else begin
                                cnt_r <= cnt_r;
                            end
                        end else if (cnt_r == CNT_LAST) begin
                            hist_r <= '0;
                            cnt_r  <= '0;
                            if (hit_s) begin
                                unlock_r <= 1'b1;
                                fail_r   <= '0;
                            end else begin
                                fail_r <= fail_inc_s;
                                if (tmr_load_s) begin
                                    state_r  <= LOCKOUT;
                                    locked_r <= 1'b1;
                                end else begin
                                    state_r  <= HUNT;
                                end
                            end
                        end else begin
                            hist_r <= cand_s[CODE_LEN-2:0];
                            cnt_r  <= cnt_r + CNT_W'(1);
                        end
                    end else begin
                        hist_r <= hist_r;
                    end
                end
                LOCKOUT: begin
                    // An idle timer while locked out also releases, so the lock can never stick.
                    if (tmr_done_s || !tmr_busy_s) begin
                        state_r  <= HUNT;
                        locked_r <= 1'b0;
                        fail_r   <= '0;
                        cnt_r    <= '0;
                        hist_r   <= '0;
                    end else begin
                        state_r  <= LOCKOUT;
                    end
                end
                default: begin
                    state_r  <= HUNT;
                    locked_r <= 1'b0;
                end
            endcase
        end
    end

    assign unlock     = unlock_r;
    assign locked_out = locked_r;
    assign fail_cnt   = fail_r;

endmodule

// File: tb/tb_dlock_param.sv
// Directed bench for dlock_param: sliding defaults, 4-bit overlap, and framed lockout instances.
module tb_dlock_param;

    logic clk;
    logic clear;

    logic       d_in_a, d_valid_a, load_en_a, unlock_a, locked_a;
    logic [5:0] load_code_a;
    logic [1:0] fail_a;

    logic       d_in_b, d_valid_b, load_en_b, unlock_b, locked_b;
    logic [3:0] load_code_b;
    logic [1:0] fail_b;

    logic       d_in_c, d_valid_c, load_en_c, unlock_c, locked_c;
    logic [5:0] load_code_c;
    logic [1:0] fail_c;

    int n_assert;
    int n_fail;
    logic [5:0] pat;

    dlock_param u_a (
        .clk(clk), .clear(clear), .d_in(d_in_a), .d_valid(d_valid_a),
        .load_en(load_en_a), .load_code(load_code_a),
        .unlock(unlock_a), .locked_out(locked_a), .fail_cnt(fail_a)
    );

    dlock_param #(.CODE_LEN(4), .DEFAULT_CODE(4'b0011)) u_b (
        .clk(clk), .clear(clear), .d_in(d_in_b), .d_valid(d_valid_b),
        .load_en(load_en_b), .load_code(load_code_b),
        .unlock(unlock_b), .locked_out(locked_b), .fail_cnt(fail_b)
    );

    dlock_param #(.OVERLAP(1'b0), .MAX_FAIL(3), .LOCKOUT_CYCLES(16)) u_c (
        .clk(clk), .clear(clear), .d_in(d_in_c), .d_valid(d_valid_c),
        .load_en(load_en_c), .load_code(load_code_c),
        .unlock(unlock_c), .locked_out(locked_c), .fail_cnt(fail_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int which, input logic b, input logic v);
        case (which)
            0:       begin d_in_a = b; d_valid_a = v; end
            1:       begin d_in_b = b; d_valid_b = v; end
            default: begin d_in_c = b; d_valid_c = v; end
        endcase
    endtask

    function automatic logic unlock_of(input int which);
        case (which)
            0:       return unlock_a;
            1:       return unlock_b;
            default: return unlock_c;
        endcase
    endfunction

    // Sends bits[n-1] first; exp[i] is the unlock expected right after bits[i] is sampled.
    task automatic send_seq(input int which, input logic [15:0] bits, input int n,
                            input logic [15:0] exp, input bit gap, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            drive(which, bits[i], 1'b1);
            tick();
            drive(which, 1'b0, 1'b0);
            check(tag, {31'd0, unlock_of(which)}, {31'd0, exp[i]});
            if (gap) begin
                tick();
                check({tag, "_gap"}, {31'd0, unlock_of(which)}, 32'd0);
            end
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        clear = 1'b1;
        d_in_a = 1'b0; d_valid_a = 1'b0; load_en_a = 1'b0; load_code_a = 6'd0;
        d_in_b = 1'b0; d_valid_b = 1'b0; load_en_b = 1'b0; load_code_b = 4'd0;
        d_in_c = 1'b0; d_valid_c = 1'b0; load_en_c = 1'b0; load_code_c = 6'd0;
        #2 clear = 1'b0;
        #2;
        check("rst_unlock_a", {31'd0, unlock_a}, 32'd0);
        check("rst_locked_c", {31'd0, locked_c}, 32'd0);
        check("rst_fail_c",   {30'd0, fail_c},   32'd0);
        check("rst_unlock_c", {31'd0, unlock_c}, 32'd0);
        #8 clear = 1'b1;

        // Sliding with the default code, twice back to back.
        send_seq(0, 16'b110100, 6, 16'b000001, 1'b0, "slide_a1");
        tick();
        check("slide_a1_end", {31'd0, unlock_a}, 32'd0);
        send_seq(0, 16'b110100, 6, 16'b000001, 1'b0, "slide_a2");
        check("slide_fail_zero", {30'd0, fail_a}, 32'd0);

        // Idle gaps between bits, then no valid bits at all.
        send_seq(0, 16'b110100, 6, 16'b000001, 1'b1, "gap_a");
        pat = 6'b110100;
        for (int i = 5; i >= 0; i--) begin
            d_in_a = pat[i];
            d_valid_a = 1'b0;
            tick();
            check("novalid_a", {31'd0, unlock_a}, 32'd0);
        end

        // Load with a simultaneous valid bit: the bit is dropped.
        load_en_a = 1'b1; load_code_a = 6'b001011; d_in_a = 1'b0; d_valid_a = 1'b1;
        tick();
        load_en_a = 1'b0; d_valid_a = 1'b0;
        check("load_discard", {31'd0, unlock_a}, 32'd0);
        send_seq(0, 16'b01011,  5, 16'b00000,  1'b0, "load_partial");
        send_seq(0, 16'b110100, 6, 16'b000000, 1'b0, "old_code");
        send_seq(0, 16'b001011, 6, 16'b000001, 1'b0, "new_code");

        // Four-bit overlapping detection.
        load_en_b = 1'b1; load_code_b = 4'b1010;
        tick();
        load_en_b = 1'b0;
        send_seq(1, 16'b101010, 6, 16'b000101, 1'b0, "overlap_b");

        // Framed: three failing frames lead to lockout.
        for (int f = 1; f <= 3; f++) begin
            send_seq(2, 16'b000000, 6, 16'b000000, 1'b0, "frame_fail");
            check("frame_fail_cnt", {30'd0, fail_c}, 32'(f));
            check("frame_locked", {31'd0, locked_c}, 32'(f == 3));
        end
        send_seq(2, 16'b110100, 6, 16'b000000, 1'b0, "lockout_ignore");
        check("lockout_locked", {31'd0, locked_c}, 32'd1);
        check("lockout_fail3",  {30'd0, fail_c},   32'd3);
        for (int k = 7; k <= 16; k++) begin
            tick();
            check("lockout_len", {31'd0, locked_c}, 32'(k < 16));
        end
        check("lockout_exit_fail", {30'd0, fail_c}, 32'd0);
        send_seq(2, 16'b000000, 6, 16'b000000, 1'b0, "post_fail");
        check("post_fail_cnt", {30'd0, fail_c}, 32'd1);
        send_seq(2, 16'b110100, 6, 16'b000001, 1'b0, "post_unlock");
        check("post_unlock_fail", {30'd0, fail_c}, 32'd0);

        // Reset in the middle of a lockout with a non-default code loaded.
        load_en_c = 1'b1; load_code_c = 6'b111111;
        tick();
        load_en_c = 1'b0;
        for (int f = 1; f <= 3; f++) begin
            send_seq(2, 16'b000000, 6, 16'b000000, 1'b0, "rst_frame");
        end
        check("rst_pre_locked", {31'd0, locked_c}, 32'd1);
        tick();
        tick();
        clear = 1'b0;
        #2;
        check("rst_mid_locked", {31'd0, locked_c}, 32'd0);
        check("rst_mid_fail",   {30'd0, fail_c},   32'd0);
        #8 clear = 1'b1;
        send_seq(2, 16'b110100, 6, 16'b000001, 1'b0, "code_revert");
        check("code_revert_fail", {30'd0, fail_c}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dlock_param.md
# dlock_param

Parametrised serial code lock, the successor of the fixed 110100 detector. It compares a serial bit stream against a CODE_LEN-bit code that is loadable at run time, and it pulses unlock on a match. There are two modes:
- **Sliding (overlapping):** detects the code anywhere in the stream.
- **Framed:** every CODE_LEN bits form one attempt. Repeated failed attempts force a timed lockout.

It sits between the serial keypad/deserialiser front end and the door-actuator controller.

## Interface
- CODE_LEN, 6: code length in bits, ≥2.
- DEFAULT_CODE, 6'b110100: code value after reset.
- OVERLAP, 1: 1 = sliding detection, 0 = framed attempts.
- MAX_FAIL, 3: consecutive framed failures that trigger lockout, ≥1.
- LOCKOUT_CYCLES, 16: lockout duration in clk cycles, ≥1.

Ports:
- clk  in  1  rising-edge clock.
- clear  in  1  asynchronous active-low reset.
- d_in  in  1  serial code bit.
- d_valid  in  1  d_in is sampled only on edges where this is 1.
- load_en  in  1  load new code this cycle.
- load_code  in  CODE_LEN  new code value.
- unlock  out  1  one-cycle match pulse.
- locked_out  out  1  high while in LOCKOUT.
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive framed failures.

## Operation
- **Bit order:** the first received bit is compared with code[CODE_LEN-1], and the last with code[0].
- **Registers:**
  - code_reg (CODE_LEN)
  - hist shift register (CODE_LEN-1 bits): hist <= {hist[CODE_LEN-3:0], d_in}
  - bit counter cnt
  - fail_cnt
  - lockout timer
  - state: HUNT, LOCKOUT
- **Reset (clear=0):**
  - state=HUNT, code_reg=DEFAULT_CODE
  - hist, cnt, fail_cnt, timer all 0
  - unlock=0, locked_out=0
- **HUNT, sliding mode:** on each valid bit:
  - match when {hist, d_in}==code_reg and cnt≥CODE_LEN-1.
  - cnt saturates at CODE_LEN-1.
  - Matches may overlap; e.g. with code 1010, the stream 101010 matches twice.
  - fail_cnt stays 0.
- **HUNT, framed mode:** on each valid bit, cnt increments. When the bit with cnt==CODE_LEN-1 arrives:
  - cnt←0 and hist←0.
  - Match → unlock pulse, fail_cnt←0.
  - Mismatch → fail_cnt+1.
  - If the new fail_cnt==MAX_FAIL → go to LOCKOUT and load timer=LOCKOUT_CYCLES-1.
- **LOCKOUT:**
  - d_valid and load_en are ignored.
  - timer decrements each cycle; at 0 → HUNT with fail_cnt, cnt and hist cleared.
- **load_en in HUNT:**
  - code_reg←load_code; hist, cnt and fail_cnt cleared.
  - It takes priority over a simultaneous d_valid; that bit is discarded and cannot produce unlock.
- d_valid=0 cycles hold all state; gaps do not break a sequence.

## Timing
- unlock is registered. It is high for exactly the one cycle after the rising edge that samples the final code bit. Consecutive sliding matches give back-to-back pulses.
- locked_out rises in the cycle after the edge sampling the MAX_FAIL-th failing bit. It stays high for exactly LOCKOUT_CYCLES cycles.
- The first valid bit is accepted on the edge after locked_out falls.
- fail_cnt updates in the same cycle as the attempt result.
- Reset mid-sequence or mid-lockout: all outputs drop immediately (asynchronously), and code_reg reverts to DEFAULT_CODE.

## Structure
- **dlock_pkg:**
  - state encoding enum (HUNT=0, LOCKOUT=1)
  - DEFAULT_CODE_6 constant
  - function clog2 for the counter widths
- **Sub-module dlock_lockout_timer:**
  - Loadable down-counter: load, load value, busy, done pulse.
  - Parameter LOCKOUT_CYCLES.
- The top level holds the shift register, comparator, fail counter and FSM.

## Test plan
- **Sliding, defaults:** stream 1,1,0,1,0,0 → unlock=1 for exactly one cycle after the 6th edge. Then 1,1,0,1,0,0 again → a second single pulse.
- **Sliding overlap:** load code 4'b1010 (CODE_LEN=4), stream 1,0,1,0,1,0 → unlock pulses after bits 4 and 6.
- **Framed lockout** (OVERLAP=0, MAX_FAIL=3, LOCKOUT_CYCLES=16):
  - Send three frames of 000000 → fail_cnt goes 1, 2, 3 and locked_out goes high for 16 cycles.
  - A correct 110100 sent during lockout → no unlock.
  - After lockout, 110100 → unlock pulse and fail_cnt=0.
- **d_valid gaps:** 110100 with d_valid=0 idle cycles between bits → unlock after the final valid bit. With all d_valid=0 → no unlock.
- **Load priority:** load_en=1 and d_valid=1 on the same edge, load_code=6'b001011 → that bit is discarded. The old code 110100 no longer unlocks; 001011 does.
- **Reset mid-lockout:** pull clear low for 10 ns during lockout → locked_out=0 and fail_cnt=0 at once. The code is 110100 again.
